s_crc16_chk: RTL and testbench

- Receive-side CRC-16 checker for the bq79606 UART link; counterpart to the transmit-side CRC16 generator.
- Sits after the UART byte receiver. Consumes framed received bytes, runs CRC-16/IBM (reflected polynomial 0xA001, init 0xFFFF, no final XOR) over data plus the two appended CRC bytes, and flags the frame good or bad.
- A correct frame (CRC appended LSB first) leaves a zero residue.
- Also supervises frame length and inter-byte timeout so the command layer only acts on verified frames.

---
 rtl/s_crc16_pkg.sv | 13 +
 rtl/crc16_byte_upd.sv | 20 ++
 rtl/s_crc16_chk.sv | 110 +++++++++++
 tb/tb_s_crc16_chk.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_crc16_pkg.sv
// Shared constants and FSM state type for the receive-side CRC-16/IBM checker.
package s_crc16_pkg;

    localparam logic [15:0] CRC_POLY_R = 16'hA001;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/crc16_byte_upd.sv
// One-byte combinational CRC-16/IBM update (reflected, LSB first on the wire).
module crc16_byte_upd
    import s_crc16_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/s_crc16_chk.sv
// Receive-side frame checker: CRC residue, length and inter-byte timeout supervision.
module s_crc16_chk
    import s_crc16_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned MIN_LEN     = 3
) (
    input  logic        sclk,
    input  logic        rest,
    input  logic        din_vld,
    input  logic [7:0]  din,
    input  logic        sof,
    input  logic        eof,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        frm_abort,
    output logic [7:0]  frame_len,
    output logic [15:0] crc_val,
    output logic        busy
);

    localparam int unsigned IdleW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC);
    localparam logic [7:0] MinLen8    = 8'(MIN_LEN);

    state_e state_q, state_d;
    logic [15:0] crc_q, crc_d, upd_in, upd_out;
    logic [7:0] cnt_q, cnt_d, len_q, len_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic ok_q, ok_d, err_q, err_d, abort_q, abort_d;
    logic start, cont, timeout;

    crc16_byte_upd u_upd (
        .crc_in  (upd_in),
        .byte_in (din),
        .crc_out (upd_out)
    );

    always_comb begin
        // Timeout cycle behaves like IDLE for any byte arriving in it.
        timeout = (state_q == StRun) && (idle_q == IdleMax);
        start   = din_vld && sof;
        cont    = (state_q == StRun) && !timeout && din_vld && !sof;
        upd_in  = start ? CRC_INIT : crc_q;

        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idle_d  = idle_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        abort_d = (state_q == StRun) && (timeout || start);

        if (start) begin
            crc_d   = upd_out;
            cnt_d   = 8'd1;
            idle_d  = '0;
            state_d = eof ? StDone : StRun;
        end else if (cont) begin
            crc_d   = upd_out;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            idle_d  = '0;
            state_d = eof ? StDone : StRun;
        end else if (timeout || state_q == StDone) begin
            idle_d  = '0;
            state_d = StIdle;
        end else if (state_q == StRun) begin
            idle_d  = idle_q + IdleW'(1);
        end

        if (state_d == StDone) begin
            ok_d  = (crc_d == 16'h0000) && (cnt_d >= MinLen8);
            err_d = !ok_d;
            len_d = cnt_d;
            // A sof+eof byte that kills an open frame reports only its own verdict.
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge sclk or posedge rest) begin
        if (rest) begin
            state_q <= StIdle;
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
            len_q   <= '0;
            idle_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idle_q  <= idle_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign frm_abort = abort_q;
    assign frame_len = len_q;
    assign crc_val   = crc_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_s_crc16_chk.sv
// Self-checking bench for s_crc16_chk: vector table plus scoreboarded CRC/verdict checks.
module tb_s_crc16_chk;

    localparam int TO = 64;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0]  din;
        logic        sof;
        logic        eof;
        logic [15:0] exp_crc;
        logic        exp_ok;
        logic [7:0]  exp_len;
    } vec_t;
    typedef vec_t vec_q_t[$];
    typedef struct { int cyc; logic [15:0] crc; } crc_exp_t;
    typedef struct { int cyc; logic ok; logic [7:0] len; } ver_exp_t;

    logic sclk = 1'b0;
    logic rest, din_vld, sof, eof;
    logic [7:0] din;
    logic crc_ok, crc_err, frm_abort, busy;
    logic [7:0] frame_len;
    logic [15:0] crc_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int abort_cnt = 0;
    int last_abort_cyc = -1;
    int excl_viol = 0;
    int ab_viol = 0;
    crc_exp_t crc_exp[$];
    ver_exp_t ver_exp[$];

    s_crc16_chk #(
        .TIMEOUT_CYC (TO),
        .MIN_LEN     (3)
    ) dut (
        .sclk      (sclk),
        .rest      (rest),
        .din_vld   (din_vld),
        .din       (din),
        .sof       (sof),
        .eof       (eof),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .frm_abort (frm_abort),
        .frame_len (frame_len),
        .crc_val   (crc_val),
        .busy      (busy)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bit-serial reference: feedback bit is crc LSB xor incoming data bit.
    function automatic logic [15:0] m_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else r = r >> 1;
        end
        return r;
    endfunction

    function automatic vec_q_t mk_frame(input byte_q_t b, input logic ok, input logic closed);
        vec_q_t q;
        vec_t v;
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < b.size(); i++) begin
            c = m_upd(c, b[i]);
            v.din = b[i];
            v.sof = (i == 0);
            v.eof = closed && (i == b.size() - 1);
            v.exp_crc = c;
            v.exp_ok = ok;
            v.exp_len = 8'(b.size());
            q.push_back(v);
        end
        return q;
    endfunction

    task automatic drive_vec(input vec_t v);
        crc_exp_t ce;
        ver_exp_t ve;
        @(posedge sclk);
        #1;
        din_vld = 1'b1;
        din = v.din;
        sof = v.sof;
        eof = v.eof;
        ce.cyc = cyc + 1;
        ce.crc = v.exp_crc;
        crc_exp.push_back(ce);
        if (v.eof) begin
            ve.cyc = cyc + 1;
            ve.ok = v.exp_ok;
            ve.len = v.exp_len;
            ver_exp.push_back(ve);
        end
    endtask

    task automatic idle_cyc();
        @(posedge sclk);
        #1;
        din_vld = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_crc_val"}, {16'h0, crc_val}, 32'hFFFF);
        chk({tag, "_frame_len"}, {24'h0, frame_len}, 32'h0);
        chk({tag, "_pulses"}, {29'h0, crc_ok, crc_err, frm_abort}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    // Scoreboard: compares crc_val and verdict pulses against expectations queued by the driver.
    always @(negedge sclk) begin
        if (!rest) begin
            while (crc_exp.size() > 0 && crc_exp[0].cyc < cyc) begin
                chk("crc_val_missed", 32'(crc_exp[0].cyc), 32'(cyc));
                void'(crc_exp.pop_front());
            end
            if (crc_exp.size() > 0 && crc_exp[0].cyc == cyc) begin
                chk("crc_val", {16'h0, crc_val}, {16'h0, crc_exp[0].crc});
                void'(crc_exp.pop_front());
            end
            if (crc_ok || crc_err) begin
                if (ver_exp.size() > 0 && ver_exp[0].cyc == cyc) begin
                    chk("crc_ok", {31'h0, crc_ok}, {31'h0, ver_exp[0].ok});
                    chk("crc_err", {31'h0, crc_err}, {31'h0, !ver_exp[0].ok});
                    chk("frame_len", {24'h0, frame_len}, {24'h0, ver_exp[0].len});
                    void'(ver_exp.pop_front());
                end else begin
                    chk("unexpected_verdict", {30'h0, crc_ok, crc_err}, 32'h0);
                end
            end else if (ver_exp.size() > 0 && ver_exp[0].cyc <= cyc) begin
                chk("verdict_missing", 32'h0, 32'h1);
                void'(ver_exp.pop_front());
            end
            if (crc_ok && crc_err) excl_viol++;
            if (frm_abort && (crc_ok || crc_err)) ab_viol++;
            if (frm_abort) begin
                abort_cnt++;
                last_abort_cyc = cyc;
            end
        end
    end

    initial begin
        vec_q_t f1v, f2v, f3v, f4v, f5v, openv, tbl;
        byte_q_t f1 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        byte_q_t f2 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                        8'h37, 8'h4B};
        byte_q_t f3 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
        byte_q_t f4 = '{8'h00};
        byte_q_t f5 = '{8'h01, 8'h02};
        byte_q_t op = '{8'h01, 8'h03, 8'h00};
        int c0, a0, exp_ab;

        f1v = mk_frame(f1, 1'b1, 1'b1);
        f2v = mk_frame(f2, 1'b1, 1'b1);
        f2v[8].exp_crc = 16'h4B37;
        f3v = mk_frame(f3, 1'b0, 1'b1);
        f4v = mk_frame(f4, 1'b0, 1'b1);
        f5v = mk_frame(f5, 1'b0, 1'b1);
        openv = mk_frame(op, 1'b0, 1'b0);
        foreach (f1v[i]) tbl.push_back(f1v[i]);
        foreach (f2v[i]) tbl.push_back(f2v[i]);
        foreach (f3v[i]) tbl.push_back(f3v[i]);
        foreach (f4v[i]) tbl.push_back(f4v[i]);
        foreach (f5v[i]) tbl.push_back(f5v[i]);

        rest = 1'b1;
        din_vld = 1'b0;
        din = 8'h00;
        sof = 1'b0;
        eof = 1'b0;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        chk_reset_vals("reset");
        @(posedge sclk);
        #1 rest = 1'b0;

        // Good, good, bad CRC, 1-byte and 2-byte frames, all back to back.
        for (int i = 0; i < tbl.size(); i++) drive_vec(tbl[i]);
        repeat (3) idle_cyc();
        @(negedge sclk);
        chk("len_held", {24'h0, frame_len}, 32'd2);
        chk("busy_idle", {31'h0, busy}, 32'h0);

        // Open frame then silence: timeout abort.
        foreach (openv[i]) drive_vec(openv[i]);
        idle_cyc();
        @(negedge sclk);
        c0 = cyc;
        chk("busy_open", {31'h0, busy}, 32'h1);
        a0 = abort_cnt;
        for (int i = 0; i < TO + 10; i++) begin
            @(posedge sclk);
            #2;
            if (abort_cnt != a0) break;
        end
        chk("timeout_abort_cnt", 32'(abort_cnt), 32'(a0 + 1));
        chk("timeout_cycle", 32'(last_abort_cyc - c0), 32'(TO + 1));
        chk("timeout_busy", {31'h0, busy}, 32'h0);
        chk("timeout_crc_kept", {16'h0, crc_val}, {16'h0, openv[2].exp_crc});

        // Open frame interrupted by a new sof; new frame must still verify.
        foreach (openv[i]) drive_vec(openv[i]);
        a0 = abort_cnt;
        exp_ab = 0;
        for (int i = 0; i < f1v.size(); i++) begin
            drive_vec(f1v[i]);
            if (i == 0) exp_ab = cyc + 1;
        end
        repeat (4) idle_cyc();
        chk("sof_abort_cnt", 32'(abort_cnt), 32'(a0 + 1));
        chk("sof_abort_cycle", 32'(last_abort_cyc), 32'(exp_ab));

        // Asynchronous reset mid-frame, then two back-to-back good frames.
        foreach (openv[i]) drive_vec(openv[i]);
        @(posedge sclk);
        @(negedge sclk);
        #2;
        rest = 1'b1;
        din_vld = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
        crc_exp.delete();
        ver_exp.delete();
        #1 chk_reset_vals("async_rst");
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        chk_reset_vals("rst_hold");
        @(posedge sclk);
        #1 rest = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < f1v.size(); i++) drive_vec(f1v[i]);
        end
        idle_cyc();

        for (int i = 0; i < 50 && (ver_exp.size() != 0 || crc_exp.size() != 0); i++)
            @(posedge sclk);
        @(negedge sclk);
        chk("pending_verdicts", 32'(ver_exp.size()), 32'h0);
        chk("ok_err_exclusive", 32'(excl_viol), 32'h0);
        chk("abort_vs_verdict", 32'(ab_viol), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
